quad_emitter: RTL and testbench
===============================

QUAD_EMITTER -- requirements
Module: quad_emitter

Interface
REQ-001 SHALL have parameter: HOLD_W, 16, width of the hold-time input.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: target  input  8  requested position; sampled only on accepted load.
REQ-005 SHALL have port: load  input  1  single-cycle request to move to target.
REQ-006 SHALL have port: hold  input  HOLD_W  cycles between quadrature edges; sampled on accepted load.
REQ-007 SHALL have port: a  output  1  quadrature phase A, registered.
REQ-008 SHALL have port: b  output  1  quadrature phase B, registered.
REQ-009 SHALL have port: position  output  8  current emitted position, registered.
REQ-010 SHALL have port: busy  output  1  high while a move is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a move completes.

Function
REQ-012 SHALL implement the states IDLE and MOVE; busy SHALL be high exactly in MOVE.
REQ-013 SHALL accept load only in IDLE; load in MOVE SHALL be ignored, with no effect on target, hold, direction or timing.
REQ-014 SHALL ignore target and hold changes when no load is accepted.
REQ-015 SHALL compute hold_eff = hold, with hold = 0 treated as 1, and latch it on accept.
REQ-016 SHALL compute diff = (target - position) mod 256 on accept:
  - diff = 0: stay in IDLE, pulse done in the cycle after the accepting edge, emit no edge.
  - diff 1..128: enter MOVE, direction forward.
  - diff 129..255: enter MOVE, direction backward.
  - Direction is latched on accept.
REQ-017 SHALL define one position unit as one quadrature edge, with {a,b} sequence:
  - forward (A leads): 00 -> 10 -> 11 -> 01 -> 00.
  - backward: the reverse order.
REQ-018 SHALL clear the hold counter on accept and increment it each MOVE cycle.
  - When the counter equals hold_eff-1, the next edge SHALL advance {a,b} one step, update position by +1 (forward) or -1 (backward), and clear the counter.
REQ-019 SHALL place the first output edge hold_eff rising edges after the accepting edge, with subsequent edges spaced exactly hold_eff cycles apart.
REQ-020 SHALL, on the edge whose step makes position equal the latched target:
  - return to IDLE;
  - deassert busy;
  - assert done for exactly one cycle.
REQ-021 SHALL wrap position modulo 256 (255+1 = 0, 0-1 = 255); the quadrature phase SHALL stay continuous across the wrap.
REQ-022 SHALL change at most one of a and b per clock edge.
REQ-023 SHALL hold a, b and position stable in IDLE and between edges in MOVE.
REQ-024 SHALL accept a new load in the cycle in which done is high (the state is IDLE).

Reset
REQ-025 SHALL, while reset is low, force asynchronously:
  - a=0, b=0, position=0, busy=0, done=0;
  - state IDLE, hold counter 0.
REQ-026 SHALL abandon any move in progress on reset, mid-operation, and SHALL NOT pulse done for the abandoned move.
REQ-027 SHALL accept a load on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover: assert reset mid-stream with toggling inputs -> a=b=0, position=0, busy=0, done=0 immediately, without waiting for a clock edge.
REQ-029 SHALL cover: from position 0, hold=4, load target=3 -> {a,b}=10,11,01 at 4,8,12 cycles after load; position 1,2,3; busy drops and done pulses at the 12th edge.
REQ-030 SHALL cover: from position 0, hold=0, load target=254 -> backward, {a,b}=01 then 11 on consecutive cycles; position 255 then 254; one done pulse.
REQ-031 SHALL cover: from position 254 forward (after REQ-030), hold=1, load target=1 -> three edges; position 255, 0, 1; sequence continues from phase 11 as 01, 00, 10.
REQ-032 SHALL cover: load with target equal to position -> done pulses next cycle; busy stays 0; a, b and position unchanged.
REQ-033 SHALL cover: during a move to 10 with hold=8, a second load with target=2 plus changes to the hold input -> ignored; the move completes at position 10 with 8-cycle spacing.

Source files
------------

// File: rtl/quad_emitter.sv
// Quadrature edge emitter: on an accepted load, walks position to target by the
// shortest direction, one A/B edge every hold_eff cycles, then pulses done.
module quad_emitter #(
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        target,
  input  logic              load,
  input  logic [HOLD_W-1:0] hold,
  output logic              a,
  output logic              b,
  output logic [7:0]        position,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t            state_q, state_d;
  logic              a_q, a_d, b_q, b_d;
  logic [7:0]        pos_q, pos_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;   // 1 = backward
  logic              done_q, done_d;
  logic [7:0]        diff;
  logic [1:0]        ab_nxt;

  // One Gray step of {a,b}: forward 00->10->11->01->00, backward reversed.
  always_comb begin
    ab_nxt = {a_q, b_q};
    if (!dir_q) begin
      case ({a_q, b_q})
        2'b00:   ab_nxt = 2'b10;
        2'b10:   ab_nxt = 2'b11;
        2'b11:   ab_nxt = 2'b01;
        default: ab_nxt = 2'b00;
      endcase
    end else begin
      case ({a_q, b_q})
        2'b00:   ab_nxt = 2'b01;
        2'b01:   ab_nxt = 2'b11;
        2'b11:   ab_nxt = 2'b10;
        default: ab_nxt = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    diff    = target - pos_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          cnt_d = '0;
          if (diff == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = MOVE;
            tgt_d   = target;
            dir_d   = (diff > 8'd128);
            hold_d  = (hold == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : hold;
          end
        end
      end
      MOVE: begin
        if (cnt_q == hold_q - 1'b1) begin
          {a_d, b_d} = ab_nxt;
          pos_d      = dir_q ? pos_q - 8'd1 : pos_q + 8'd1;
          cnt_d      = '0;
          if (pos_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pos_q   <= '0;
      tgt_q   <= '0;
      hold_q  <= {{(HOLD_W-1){1'b0}}, 1'b1};
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign position = pos_q;
  assign busy     = (state_q == MOVE);
  assign done     = done_q;

endmodule

// File: tb/tb_quad_emitter.sv
// Randomized bench for quad_emitter against a move-level model: position follows
// start +/- floor(cycles/hold_eff), and the A/B phase is fixed by position mod 4.
module tb_quad_emitter;

  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        target = '0;
  logic              load = 1'b0;
  logic [HOLD_W-1:0] hold = '0;
  logic              a, b, busy, done;
  logic [7:0]        position;

  int errors = 0;
  int checks = 0;
  int m_pos  = 0;

  quad_emitter #(.HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset(reset), .target(target), .load(load), .hold(hold),
    .a(a), .b(b), .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] phase_of(input int p);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
    return tbl[p & 3];
  endfunction

  // Sample at c=0 is just after the accepting edge; c counts edges after it.
  task automatic test_move(input string name, input int tgt, input int hld,
                           input bit intf, input bit b2b);
    int d, n, h, total, start, steps, last, ep;
    bit back;
    logic [11:0] got, exp;
    start = m_pos;
    d     = (tgt - m_pos) & 255;
    back  = (d > 128);
    n     = back ? 256 - d : d;
    h     = (hld == 0) ? 1 : hld;
    total = n * h;
    last  = b2b ? total : total + 1;
    @(negedge clk);
    target = tgt[7:0]; hold = hld[HOLD_W-1:0]; load = 1'b1;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(negedge clk);
        load = 1'b0;
        if (intf) begin
          target = ($urandom_range(0, 1) == 1) ? 8'd2 : 8'($urandom);
          hold   = HOLD_W'($urandom_range(0, 20));
          if (c <= total && $urandom_range(0, 2) == 0) load = 1'b1;
        end
      end
      @(posedge clk); #1;
      steps = c / h;
      if (steps > n) steps = n;
      ep  = (start + (back ? -steps : steps)) & 255;
      exp = {phase_of(ep), 8'(ep), (c < total), (c == total)};
      got = {a, b, position, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s c=%0d got ab=%b pos=%0d busy=%b done=%b want ab=%b pos=%0d busy=%b done=%b",
                 name, c, got[11:10], got[9:2], got[1], got[0],
                 exp[11:10], exp[9:2], exp[1], exp[0]);
      end
    end
    load = 1'b0;
    m_pos = tgt & 255;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({a, b, position, busy, done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_init got %b want 0", {a, b, position, busy, done});
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    m_pos = 0;
  endtask

  task automatic test_hold4;      test_move("hold4_fwd", 3, 4, 0, 0);   endtask
  task automatic test_hold0_back; test_move("hold0_back", 254, 0, 0, 0); endtask
  task automatic test_wrap;       test_move("wrap_fwd", 1, 1, 0, 0);    endtask

  task automatic test_same_target;
    test_move("same_target", m_pos, $urandom_range(0, 9), 0, 0);
  endtask

  task automatic test_ignore_load;
    test_move("ignore_load", 10, 8, 1, 0);
  endtask

  task automatic test_back_to_back;
    test_move("b2b_first", 20, 2, 0, 1);
    test_move("b2b_second", 15, 3, 0, 1);
    test_move("b2b_same", 15, 5, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      test_move("random", $urandom_range(0, 255), $urandom_range(0, 4),
                $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    target = 8'd60; hold = 16'd3; load = 1'b1;
    repeat (10) begin
      @(negedge clk);
      load = $urandom_range(0, 1); target = 8'($urandom); hold = HOLD_W'($urandom);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({a, b, position, busy, done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async got %b want 0", {a, b, position, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      load = $urandom_range(0, 1); target = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({a, b, position, busy, done} !== 12'd0) begin
        errors++;
        $display("FAIL reset_held got %b want 0", {a, b, position, busy, done});
      end
    end
    #2 reset = 1'b1;
    load = 1'b0;
    m_pos = 0;
    test_move("after_reset", 5, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_hold4();
    test_hold0_back();
    test_wrap();
    test_same_target();
    test_ignore_load();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
